// File: rtl/ravens_pkt_tx_if.sv
// Packet-in / byte-out bundle between the RAVENS event stage, the packet
// transmitter and the processor link, plus the transmitter's status outputs.
interface ravens_pkt_tx_if #(
    parameter int unsigned PKT_BITS      = 32,
    parameter int unsigned FIFO_DEPTH    = 8,
    parameter int unsigned DROP_CNT_BITS = 16
);
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic [PKT_BITS-1:0]      pkt_in;
    logic                     pkt_valid;
    logic [7:0]               tx_data;
    logic                     tx_valid;
    logic                     tx_ready;
    logic                     tx_last;
    logic [CNT_W-1:0]         fifo_count;
    logic                     full;
    logic [DROP_CNT_BITS-1:0] drop_cnt;

    modport master (
        output pkt_in, pkt_valid, tx_ready,
        input  tx_data, tx_valid, tx_last, fifo_count, full, drop_cnt
    );

    modport slave (
        input  pkt_in, pkt_valid, tx_ready,
        output tx_data, tx_valid, tx_last, fifo_count, full, drop_cnt
    );
endinterface

// File: rtl/ravens_pkt_tx.sv
// Buffers RAVENS event packets in a small FIFO and serializes them MSB-byte-first
// onto a valid/ready byte link, counting packets dropped on overflow.
module ravens_pkt_tx #(
    parameter int unsigned PKT_BITS      = 32,
    parameter int unsigned FIFO_DEPTH    = 8,
    parameter int unsigned DROP_CNT_BITS = 16
) (
    input  logic           clk,
    input  logic           rst,
    ravens_pkt_tx_if.slave bus
);
    localparam int unsigned NBYTES = PKT_BITS / 8;
    localparam int unsigned AW     = $clog2(FIFO_DEPTH);
    localparam int unsigned CW     = AW + 1;
    localparam int unsigned IW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    typedef enum logic {IDLE, SEND} state_e;

    state_e                   state_q, state_d;
    logic [PKT_BITS-1:0]      mem [FIFO_DEPTH];
    logic [AW-1:0]            wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]            count_q, count_d;
    logic                     full_q, full_d;
    logic [DROP_CNT_BITS-1:0] drop_q, drop_d;
    logic [PKT_BITS-1:0]      shift_q, shift_d;
    logic [IW-1:0]            idx_q, idx_d;
    logic                     valid_q, valid_d;
    logic                     last_q, last_d;
    logic                     push, pop, hs;

    // Writes are judged against the registered full flag, so a pop in the same cycle cannot rescue them.
    assign push = bus.pkt_valid && !full_q;
    assign hs   = (state_q == SEND) && bus.tx_ready;

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // A pop on the last handshake keeps SEND and streams the next packet without a bubble.
    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (count_q != '0) begin
                    pop     = 1'b1;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (hs && last_q) begin
                    if (count_q != '0) pop = 1'b1;
                    else               state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        shift_d = shift_q;
        idx_d   = idx_q;
        if (pop) begin
            shift_d = mem[rd_ptr_q];
            idx_d   = '0;
        end else if (hs) begin
            shift_d = shift_q << 8;
            idx_d   = idx_q + IW'(1);
        end
        valid_d = (state_d == SEND);
        last_d  = (state_d == SEND) && (idx_d == IW'(NBYTES - 1));
    end

    always_comb begin
        count_d = count_q + CW'(push) - CW'(pop);
        full_d  = (count_d == CW'(FIFO_DEPTH));
        drop_d  = drop_q;
        if (bus.pkt_valid && full_q && (drop_q != '1)) drop_d = drop_q + DROP_CNT_BITS'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst && push) mem[wr_ptr_q] <= bus.pkt_in;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            drop_q   <= '0;
            shift_q  <= '0;
            idx_q    <= '0;
            valid_q  <= 1'b0;
            last_q   <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_d;
            full_q  <= full_d;
            drop_q  <= drop_d;
            shift_q <= shift_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
            last_q  <= last_d;
        end
    end

    assign bus.tx_data    = shift_q[PKT_BITS-1 -: 8];
    assign bus.tx_valid   = valid_q;
    assign bus.tx_last    = last_q;
    assign bus.fifo_count = count_q;
    assign bus.full       = full_q;
    assign bus.drop_cnt   = drop_q;
endmodule

// File: tb/tb_ravens_pkt_tx.sv
// Self-checking bench for ravens_pkt_tx: directed scenarios plus random traffic
// compared every cycle against a queue-based packet/byte model.
module tb_ravens_pkt_tx;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ravens_pkt_tx_if #(.PKT_BITS(32), .FIFO_DEPTH(8), .DROP_CNT_BITS(16)) if1 ();
    ravens_pkt_tx_if #(.PKT_BITS(32), .FIFO_DEPTH(8), .DROP_CNT_BITS(2))  if2 ();

    ravens_pkt_tx #(.PKT_BITS(32), .FIFO_DEPTH(8), .DROP_CNT_BITS(16)) dut (
        .clk(clk), .rst(rst), .bus(if1.slave));
    ravens_pkt_tx #(.PKT_BITS(32), .FIFO_DEPTH(8), .DROP_CNT_BITS(2)) dut_sat (
        .clk(clk), .rst(rst), .bus(if2.slave));

    int total = 0;
    int bad   = 0;

    // Model: packets waiting in the FIFO, and the bytes of the packet on the link.
    logic [31:0] mq[$];
    logic [7:0]  cur[$];
    int unsigned mdrop = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_step(input logic v, input logic [31:0] p, input logic r, input logic rs);
        logic        was_full;
        logic        do_pop;
        logic [31:0] pk;
        if (rs) begin
            mq.delete();
            cur.delete();
            mdrop = 0;
        end else begin
            was_full = (mq.size() == 8);
            do_pop   = 1'b0;
            if (cur.size() == 0) begin
                do_pop = (mq.size() > 0);
            end else if (r) begin
                void'(cur.pop_front());
                if (cur.size() == 0 && mq.size() > 0) do_pop = 1'b1;
            end
            if (do_pop) begin
                pk = mq.pop_front();
                for (int b = 3; b >= 0; b--) cur.push_back(pk[b*8 +: 8]);
            end
            if (v) begin
                if (!was_full)          mq.push_back(p);
                else if (mdrop < 65535) mdrop++;
            end
        end
    endtask

    task automatic cyc(input logic v, input logic [31:0] p, input logic r, input logic rs);
        if1.pkt_valid = v;
        if1.pkt_in    = p;
        if1.tx_ready  = r;
        rst           = rs;
        @(posedge clk);
        model_step(v, p, r, rs);
        #1;
        check("tx_valid", 32'(if1.tx_valid), 32'(cur.size() > 0));
        check("fifo_count", 32'(if1.fifo_count), 32'(mq.size()));
        check("full", 32'(if1.full), 32'(mq.size() == 8));
        check("drop_cnt", 32'(if1.drop_cnt), 32'(mdrop));
        if (cur.size() > 0) begin
            check("tx_data", 32'(if1.tx_data), 32'(cur[0]));
            check("tx_last", 32'(if1.tx_last), 32'(cur.size() == 1));
        end
    endtask

    initial begin
        int nvalid;
        int first;
        int lastmask;
        if1.pkt_valid = 1'b0; if1.pkt_in = '0; if1.tx_ready = 1'b0;
        if2.pkt_valid = 1'b0; if2.pkt_in = '0; if2.tx_ready = 1'b0;

        // Reset
        repeat (3) cyc(1'b1, 32'hDEAD_BEEF, 1'b1, 1'b1);
        check("rst_tx_data", 32'(if1.tx_data), 32'h0);
        check("rst_tx_last", 32'(if1.tx_last), 32'h0);

        // Single packet, link always ready
        cyc(1'b1, 32'h0001_2340, 1'b1, 1'b0);
        check("lat_edge1_valid", 32'(if1.tx_valid), 32'h0);
        check("lat_edge1_count", 32'(if1.fifo_count), 32'h1);
        cyc(1'b0, 32'h0, 1'b1, 1'b0);
        check("lat_edge2_valid", 32'(if1.tx_valid), 32'h1);
        check("first_byte", 32'(if1.tx_data), 32'h00);
        repeat (6) cyc(1'b0, 32'h0, 1'b1, 1'b0);
        check("single_idle", 32'(if1.tx_valid), 32'h0);

        // Backpressure after the second byte
        cyc(1'b1, 32'h0001_2340, 1'b1, 1'b0);
        cyc(1'b0, 32'h0, 1'b1, 1'b0);
        cyc(1'b0, 32'h0, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            cyc(1'b0, 32'h0, 1'b0, 1'b0);
            check("bp_hold_data", 32'(if1.tx_data), 32'h01);
        end
        repeat (6) cyc(1'b0, 32'h0, 1'b1, 1'b0);

        // Overflow: ten packets into a stalled link
        for (int k = 1; k <= 10; k++) cyc(1'b1, 32'(k), 1'b0, 1'b0);
        check("ovf_full", 32'(if1.full), 32'h1);
        check("ovf_count", 32'(if1.fifo_count), 32'h8);
        check("ovf_drop", 32'(if1.drop_cnt), 32'h1);
        repeat (40) cyc(1'b0, 32'h0, 1'b1, 1'b0);
        check("ovf_drained", 32'(if1.tx_valid), 32'h0);

        // Back-to-back streaming
        nvalid = 0; first = -1; lastmask = 0;
        for (int i = 0; i < 18; i++) begin
            cyc(i < 3, 32'hA0B0_C0D0 + 32'(i), 1'b1, 1'b0);
            if (if1.tx_valid) begin
                if (first < 0) first = i;
                nvalid++;
                if (if1.tx_last) lastmask |= (1 << (i - first));
            end
        end
        check("b2b_valid_cycles", 32'(nvalid), 32'd12);
        check("b2b_last_pos", 32'(lastmask), 32'h888);

        // Reset during the first packet with more queued
        for (int k = 0; k < 3; k++) cyc(1'b1, 32'h1111_0000 + 32'(k), 1'b0, 1'b0);
        cyc(1'b0, 32'h0, 1'b1, 1'b0);
        cyc(1'b0, 32'h0, 1'b1, 1'b0);
        cyc(1'b1, 32'h5555_5555, 1'b1, 1'b1);
        check("mid_rst_valid", 32'(if1.tx_valid), 32'h0);
        check("mid_rst_count", 32'(if1.fifo_count), 32'h0);
        check("mid_rst_drop", 32'(if1.drop_cnt), 32'h0);
        cyc(1'b1, 32'h89AB_CDEF, 1'b1, 1'b0);
        repeat (8) cyc(1'b0, 32'h0, 1'b1, 1'b0);

        // Random traffic
        for (int i = 0; i < 400; i++)
            cyc($urandom_range(0, 2) == 0, $urandom, $urandom_range(0, 3) != 0, 1'b0);
        repeat (50) cyc(1'b0, 32'h0, 1'b1, 1'b0);

        // Drop counter saturation on the 2-bit instance
        for (int k = 0; k < 29; k++) begin
            if2.pkt_valid = 1'b1;
            if2.pkt_in    = 32'(k);
            cyc(1'b0, 32'h0, 1'b1, 1'b0);
            check("sat_drop", 32'(if2.drop_cnt), (k >= 9) ? 32'((k - 8 > 3) ? 3 : k - 8) : 32'h0);
        end
        if2.pkt_valid = 1'b0;
        cyc(1'b0, 32'h0, 1'b1, 1'b0);
        check("sat_drop_hold", 32'(if2.drop_cnt), 32'd3);
        check("sat_full", 32'(if2.full), 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
